// File: rtl/decode_pkg.sv
// Types and decode helpers shared by the decode sequencer and its micro-op queue.
package decode_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_AMO    = 7'b0101111,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    localparam logic [4:0] F5_LR = 5'b00010;
    localparam logic [4:0] F5_SC = 5'b00011;

    typedef enum logic [1:0] {
        PH_SINGLE = 2'b00,
        PH_AMO_LD = 2'b01,
        PH_AMO_ST = 2'b10
    } phase_e;

    typedef enum logic {
        ST_IDLE,
        ST_AMO_ST
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic       jump;
        logic [1:0] alu_op;
        logic       lui;
        logic       auipc;
        logic       jal;
        logic       r_type;
        logic       sys_inst;
        logic       is_atomic;
        logic       illegal;
    } ctrl_t;

    // For a two-uop AMO this returns the controls of the leading load uop.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode, input logic [4:0] funct5,
                                          input bit en_atomic, input bit en_csr);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_REG:    begin c.reg_write = 1'b1; c.r_type = 1'b1; c.alu_op = 2'b11; end
            OP_IMM:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 2'b01; end
            OP_LOAD:   begin
                c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1;
            end
            OP_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
            OP_BRANCH: begin c.branch = 1'b1; c.alu_op = 2'b10; end
            OP_JAL:    begin c.jump = 1'b1; c.jal = 1'b1; c.reg_write = 1'b1; end
            OP_JALR:   begin c.jump = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1; end
            OP_LUI:    begin c.reg_write = 1'b1; c.lui = 1'b1; c.alu_src = 1'b1; end
            OP_AUIPC:  begin c.reg_write = 1'b1; c.auipc = 1'b1; c.alu_src = 1'b1; end
            OP_SYSTEM: begin
                if (en_csr) begin c.sys_inst = 1'b1; c.reg_write = 1'b1; end
                else        c.illegal = 1'b1;
            end
            OP_AMO:    begin
                if (!en_atomic) begin
                    c.illegal = 1'b1;
                end else begin
                    c.is_atomic = 1'b1;
                    c.reg_write = 1'b1;
                    if (funct5 == F5_SC) begin
                        c.mem_write = 1'b1;
                    end else begin
                        c.mem_read   = 1'b1;
                        c.mem_to_reg = 1'b1;
                    end
                end
            end
            default:   c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic is_amo_pair(input logic [6:0] opcode, input logic [4:0] funct5,
                                         input bit en_atomic);
        return en_atomic && (opcode == OP_AMO) && (funct5 != F5_LR) && (funct5 != F5_SC);
    endfunction

    function automatic ctrl_t amo_store_ctrl();
        ctrl_t c;
        c = '0;
        c.is_atomic = 1'b1;
        c.mem_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/uop_fifo.sv
// Registered circular FIFO for micro-ops; entries become visible the cycle after the push.
module uop_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  T                     push_data,
    input  logic                 pop,
    output T                     pop_data,
    output logic                 valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // A full queue refuses a push even if it is popped in the same cycle.
    assign do_push = push && (count_q != FULL_CNT);
    assign do_pop  = pop && (count_q != '0);

    // NOTE: next-state logic uses blocking '=' in always_comb; registers update only with '<='.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; the read port is gated by valid so stale entries never escape.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign valid    = (count_q != '0);
    assign count    = count_q;
    assign pop_data = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/decode_sequencer.sv
// Decodes instructions into micro-ops and queues them; read-modify-write AMOs
// are split into a load uop followed by a store uop.
module decode_sequencer
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter bit EN_ATOMIC = 1'b1,
    parameter bit EN_CSR    = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output ctrl_t                      out_ctrl,
    output logic [1:0]                 out_phase,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(BUF_DEPTH):0] occupancy
);
    localparam int            CW       = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    typedef struct packed {
        ctrl_t           ctrl;
        phase_e          phase;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } uop_t;

    state_e state_q;
    uop_t   amo_st_q;
    uop_t   push_uop, pop_uop;
    ctrl_t  dec_ctrl;
    logic   dec_pair, full, accept, push, pop;

    assign dec_ctrl = decode_ctrl(in_instr[6:0], in_instr[31:27], EN_ATOMIC, EN_CSR);
    assign dec_pair = is_amo_pair(in_instr[6:0], in_instr[31:27], EN_ATOMIC);

    // Readiness counts only entries present before this edge, never a same-cycle pop.
    assign full     = (occupancy == FULL_CNT);
    assign in_ready = (state_q == ST_IDLE) && !full && !flush && !reset;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        push     = 1'b0;
        push_uop = '0;
        if (state_q == ST_AMO_ST) begin
            push     = !full && !flush;
            push_uop = amo_st_q;
        end else begin
            push           = accept;
            push_uop.ctrl  = dec_ctrl;
            push_uop.phase = dec_pair ? PH_AMO_LD : PH_SINGLE;
            push_uop.instr = in_instr;
            push_uop.pc    = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            amo_st_q <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && dec_pair) begin
                        state_q  <= ST_AMO_ST;
                        amo_st_q <= '{ctrl: amo_store_ctrl(), phase: PH_AMO_ST,
                                      instr: in_instr, pc: in_pc};
                    end
                end
                ST_AMO_ST: begin
                    if (push) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uop_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (uop_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_uop),
        .pop       (pop),
        .pop_data  (pop_uop),
        .valid     (out_valid),
        .count     (occupancy)
    );

    assign out_ctrl  = pop_uop.ctrl;
    assign out_phase = pop_uop.phase;
    assign out_instr = pop_uop.instr;
    assign out_pc    = pop_uop.pc;

endmodule
